// File: rtl/div_seq.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned,
// divide-by-zero flag, start/ready handshake and annulment.
module div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 annul_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic                 div_zero_o,
   output logic [2*WIDTH-1:0]   result_o
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic                 div_zero_q, div_zero_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 sign1, sign2;
   logic [WIDTH:0]       rem_sh, trial;
   logic [WIDTH-1:0]     rem_nx, quo_nx;

   function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   // Next-state, datapath step and registered-output values
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      cnt_d      = cnt_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      result_d   = result_q;

      sign1  = signed_i & opdata1_i[WIDTH-1];
      sign2  = signed_i & opdata2_i[WIDTH-1];
      // Trial subtraction is one bit wider so its MSB acts as the borrow
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

      case (state_q)
         IDLE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d    = DONE;
                  result_d   = {opdata1_i, {WIDTH{1'b1}}};
                  div_zero_d = 1'b1;
               end else begin
                  state_d   = BUSY;
                  quo_d     = sign1 ? twos(opdata1_i) : opdata1_i;
                  dvs_d     = sign2 ? twos(opdata2_i) : opdata2_i;
                  neg_quo_d = sign1 ^ sign2;
                  neg_rem_d = sign1;
                  rem_d     = '0;
                  cnt_d     = '0;
               end
            end
         end
         BUSY: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d    = DONE;
                  result_d   = {neg_rem_q ? twos(rem_nx) : rem_nx,
                                neg_quo_q ? twos(quo_nx) : quo_nx};
                  div_zero_d = 1'b0;
               end
            end
         end
         DONE: begin
            if (annul_i || !start_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d == BUSY);
      ready_d = (state_d == DONE);
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         div_zero_q <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         cnt_q      <= cnt_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         div_zero_q <= div_zero_d;
         result_q   <= result_d;
      end
   end

   assign busy_o     = busy_q;
   assign ready_o    = ready_q;
   assign div_zero_o = div_zero_q;
   assign result_o   = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq at WIDTH=32 and WIDTH=8.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        resetn;

   logic        start32, signed32, annul32;
   logic [31:0] a32, b32;
   logic        busy32, ready32, dz32;
   logic [63:0] res32;

   logic        start8, signed8, annul8;
   logic [7:0]  a8, b8;
   logic        busy8, ready8, dz8;
   logic [15:0] res8;

   int nvec = 0;
   int nmis = 0;

   typedef struct {
      bit          sel8;
      bit          sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      bit          dz;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic        dz;
      int          lat;
      int          nbusy;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   logic [63:0] prev_res32;
   logic        prev_dz32;

   always #5 clk = ~clk;

   div_seq #(.WIDTH(32)) u_div32 (
      .clk(clk), .resetn(resetn), .start_i(start32), .signed_i(signed32),
      .opdata1_i(a32), .opdata2_i(b32), .annul_i(annul32),
      .busy_o(busy32), .ready_o(ready32), .div_zero_o(dz32), .result_o(res32)
   );

   div_seq #(.WIDTH(8)) u_div8 (
      .clk(clk), .resetn(resetn), .start_i(start8), .signed_i(signed8),
      .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
      .busy_o(busy8), .ready_o(ready8), .div_zero_o(dz8), .result_o(res8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one divide, wait for ready (bounded), compare against the scoreboard
   task automatic run_op(input vec_t v);
      exp_t e;
      exp_t got;
      int   wd;
      int   n;
      int   nb;
      logic rdy;
      logic bsy;
      wd      = v.sel8 ? 8 : 32;
      e.res   = v.sel8 ? {48'b0, v.r[7:0], v.q[7:0]} : {v.r, v.q};
      e.dz    = v.dz;
      e.lat   = v.dz ? 1 : wd + 1;
      e.nbusy = v.dz ? 0 : wd;
      sb.push_back(e);

      @(negedge clk);
      if (v.sel8) begin
         signed8 = v.sg; a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1;
      end else begin
         signed32 = v.sg; a32 = v.a; b32 = v.b; start32 = 1'b1;
      end
      n  = 0;
      nb = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
         rdy = v.sel8 ? ready8 : ready32;
         bsy = v.sel8 ? busy8 : busy32;
         if (bsy) nb++;
      end while (!rdy && n < 200);
      start8  = 1'b0;
      start32 = 1'b0;

      got.res   = v.sel8 ? {48'b0, res8} : res32;
      got.dz    = v.sel8 ? dz8 : dz32;
      got.lat   = n;
      got.nbusy = nb;
      e = sb.pop_front();
      check("ready_seen", 64'(rdy), 64'(1));
      check("latency", 64'(got.lat), 64'(e.lat));
      check("busy_cycles", 64'(got.nbusy), 64'(e.nbusy));
      check("result", got.res, e.res);
      check("div_zero", 64'(got.dz), 64'(e.dz));
      if (!v.sel8) begin
         prev_res32 = e.res;
         prev_dz32  = e.dz;
      end

      @(posedge clk);
      #1;
      rdy = v.sel8 ? ready8 : ready32;
      check("ready_drop", 64'(rdy), 64'(0));
   endtask

   initial begin
      int cnt;
      bit seen;
      vec_t v;

      // {sel8, signed, a, b, quotient, remainder, div_zero}
      tbl.push_back('{0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          0});
      tbl.push_back('{0, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0});
      tbl.push_back('{0, 1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0});
      tbl.push_back('{0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0});
      tbl.push_back('{0, 0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0});
      tbl.push_back('{0, 0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          0});
      tbl.push_back('{0, 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  0});
      tbl.push_back('{0, 0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1});
      tbl.push_back('{0, 1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1});
      tbl.push_back('{0, 0, 32'd3,          32'd10,         32'd0,          32'd3,          0});
      tbl.push_back('{0, 1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          0});
      tbl.push_back('{0, 0, 32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          0});
      tbl.push_back('{1, 0, 32'd200,        32'd3,          32'd66,         32'd2,          0});
      tbl.push_back('{1, 1, 32'h80,         32'h7F,         32'hFF,         32'hFF,         0});
      tbl.push_back('{1, 1, 32'h80,         32'hFF,         32'h80,         32'h00,         0});
      tbl.push_back('{1, 0, 32'd7,          32'd8,          32'd0,          32'd7,          0});
      tbl.push_back('{1, 1, 32'h85,         32'h03,         32'hD7,         32'h00,         0});
      tbl.push_back('{1, 0, 32'hFF,         32'h00,         32'hFF,         32'hFF,         1});

      start32 = 1'b0; signed32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
      start8  = 1'b0; signed8  = 1'b0; annul8  = 1'b0; a8  = '0; b8  = '0;
      prev_res32 = '0;
      prev_dz32  = 1'b0;

      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1;
      check("rst_busy32", 64'(busy32), 64'(0));
      check("rst_ready32", 64'(ready32), 64'(0));
      check("rst_dz32", 64'(dz32), 64'(0));
      check("rst_result32", res32, 64'(0));
      check("rst_ready8", 64'(ready8), 64'(0));
      check("rst_result8", 64'(res8), 64'(0));
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      foreach (tbl[i]) run_op(tbl[i]);

      // Divide-by-zero with start held for three cycles
      @(negedge clk);
      signed32 = 1'b0; a32 = 32'd5; b32 = 32'd0; start32 = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (ready32) cnt++;
      end
      start32 = 1'b0;
      check("hold_ready_cycles", 64'(cnt), 64'(3));
      check("hold_dz", 64'(dz32), 64'(1));
      check("hold_result", res32, {32'd5, 32'hFFFF_FFFF});
      @(posedge clk);
      #1;
      check("hold_ready_drop", 64'(ready32), 64'(0));
      prev_res32 = {32'd5, 32'hFFFF_FFFF};
      prev_dz32  = 1'b1;

      // Annul on the 10th busy cycle
      @(negedge clk);
      signed32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
      end
      check("annul_busy_before", 64'(busy32), 64'(1));
      annul32 = 1'b1;
      start32 = 1'b0;
      @(posedge clk);
      #1;
      annul32 = 1'b0;
      check("annul_busy_after", 64'(busy32), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready32 || busy32) seen = 1'b1;
      end
      check("annul_no_ready", 64'(seen), 64'(0));
      check("annul_result_held", res32, prev_res32);
      check("annul_dz_held", 64'(dz32), 64'(prev_dz32));
      v = '{0, 0, 32'd9, 32'd3, 32'd3, 32'd0, 0};
      run_op(v);

      // Start and annul together in IDLE: nothing starts
      @(negedge clk);
      a32 = 32'd50; b32 = 32'd5; start32 = 1'b1; annul32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0; annul32 = 1'b0;
      check("idle_annul_busy", 64'(busy32), 64'(0));
      check("idle_annul_ready", 64'(ready32), 64'(0));

      // Asynchronous reset in the middle of BUSY
      @(negedge clk);
      a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
      end
      check("mid_busy", 64'(busy32), 64'(1));
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy32), 64'(0));
      check("mid_rst_ready", 64'(ready32), 64'(0));
      check("mid_rst_dz", 64'(dz32), 64'(0));
      check("mid_rst_result", res32, 64'(0));
      start32 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      v = '{0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0};
      run_op(v);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised iterative restoring divider for the EX stage. It produces one quotient bit per cycle over WIDTH cycles, handles signed and unsigned operands, and flags divide-by-zero. It uses a start/ready handshake, so EX holds its stall request until ready_o is seen. It supports annulment (flush) and generalises the fixed 32-bit divider to any operand width.

## Interface
- WIDTH, 32: operand width in bits; legal values are 4 and above.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start_i  in  1  request a divide; operands are sampled in IDLE.
- signed_i  in  1  1 selects two's-complement operands, 0 selects unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- annul_i  in  1  abort the operation in progress.
- busy_o  out  1  high while in BUSY.
- ready_o  out  1  result valid; high only in DONE.
- div_zero_o  out  1  the last completed operation had divisor 0.
- result_o  out  2*WIDTH  {remainder, quotient}.

## Operation
- States: IDLE, BUSY, DONE. The state register and all outputs are registered.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i=0: go to DONE. Load result_o={opdata1_i, all ones} and div_zero_o=1.
  - start_i=1 and annul_i=0 and opdata2_i≠0: latch the operand magnitudes. In signed mode, negate any operand whose MSB is 1.
  - In the same (nonzero-divisor) case, latch neg_q=signed_i&(sign1^sign2) and neg_r=signed_i&sign1. Clear the partial remainder and clear counter, which is $clog2(WIDTH)+1 bits wide. Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, one step per cycle:
  - Shift {rem, dividend} left by 1 and form trial = rem − divisor (WIDTH+1 bits).
  - If trial is non-negative, rem=trial and shift in a quotient bit of 1; else keep rem and shift in 0.
  - counter increments by 1.
  - annul_i=1 has priority: go to IDLE. result_o and div_zero_o are left unchanged, and ready_o is never raised.
  - After the step with counter=WIDTH−1, go to DONE. On that transition:
    - result_o gets the sign-corrected values: quotient negated if neg_q, remainder negated if neg_r.
    - div_zero_o=0.
- DONE: ready_o=1. Stay in DONE while start_i=1; go to IDLE on the first cycle start_i=0. annul_i in DONE also returns to IDLE.
- Arithmetic:
  - All results are taken mod 2^WIDTH.
  - Signed most-negative ÷ −1 gives quotient = most-negative and remainder 0. There is no overflow flag.
  - The remainder takes the dividend's sign; the quotient truncates toward zero.
- result_o and div_zero_o hold their values in IDLE until the next completion.
- start_i is ignored in BUSY and DONE; operands cannot change mid-operation.
- Asynchronous reset at any time, including mid-BUSY:
  - State goes to IDLE.
  - busy_o, ready_o, div_zero_o and result_o go to 0.
  - counter and internal registers are cleared.

## Timing
- Reset values: busy_o=0, ready_o=0, div_zero_o=0, result_o=0.
- Normal divide: start_i sampled at edge E.
  - busy_o is high for cycles E+1 through E+WIDTH.
  - ready_o is high from edge E+WIDTH+1, i.e. latency WIDTH+1 edges (33 at WIDTH=32).
- Divide-by-zero: ready_o is high after edge E+1, i.e. latency 1.
- Handshake: ready_o stays asserted for as long as start_i stays high.
  - EX drives start_i low combinationally once ready_o is seen, so DONE normally lasts exactly 1 cycle.
  - A new start_i is accepted no earlier than the cycle after DONE exits to IDLE.
- Annul: annul_i sampled high at edge A in BUSY gives busy_o=0 after A. ready_o stays 0.
- Simultaneous start_i and annul_i in IDLE: annul_i wins and no operation starts.

## Test plan
- Unsigned, WIDTH=32: 100 ÷ 7 → quotient=14, remainder=2, div_zero_o=0. ready_o rises exactly 33 edges after the start edge, and busy_o is high for 32 cycles.
- Signed, WIDTH=32:
  - −7 ÷ 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7 ÷ −2 → quotient=0xFFFFFFFD, remainder=1.
  - 0x80000000 ÷ 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: 5 ÷ 0 (signed or unsigned) → ready_o after 1 edge, div_zero_o=1, result_o={0x00000005, 0xFFFFFFFF}. Holding start_i for 3 cycles keeps ready_o high for 3 cycles.
- Annul: start 100 ÷ 7, raise annul_i on the 10th BUSY cycle → busy_o drops the next cycle, ready_o stays 0 for 40 cycles, and result_o keeps its previous value. A following 9 ÷ 3 then gives quotient=3, remainder=0.
- Reset mid-operation: drop resetn during BUSY cycle 5 → all outputs are 0 immediately, without waiting for a clock edge. After release, 100 ÷ 7 completes correctly.
- WIDTH=8: unsigned 200 ÷ 3 → quotient=66, remainder=2 with ready_o 9 edges after start. Signed 0x80 ÷ 0x7F → quotient=0xFF, remainder=0xFF.
